// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// commit modes and default latencies.
package md_sequencer_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } md_state_t;

    // How the pending result is folded into {hi,lo} when the op completes.
    typedef enum logic [1:0] {
        ACC_SET  = 2'd0,
        ACC_KEEP = 2'd1,
        ACC_ADD  = 2'd2,
        ACC_SUB  = 2'd3
    } md_acc_t;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_sequencer_if.sv
// Pipeline-side bus of the multiply/divide sequencer.
interface md_sequencer_if;

    logic        start;
    logic [3:0]  md_op;
    logic        cancel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        md_active;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    modport master (
        output start, md_op, cancel, rs_data, rt_data,
        input  busy, md_active, hi, lo, md_rdata
    );

    modport slave (
        input  start, md_op, cancel, rs_data, rt_data,
        output busy, md_active, hi, lo, md_rdata
    );

endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational 32x32 multiply and divide datapath (product, quotient, remainder).
module md_arith (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic [63:0] a_ext, b_ext;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

    always_comb begin
        a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;

        // Sign-magnitude division: truncates toward zero, and 0x80000000 / -1
        // wraps to 0x80000000 naturally through the unsigned magnitude path.
        a_neg    = is_signed & a[31];
        b_neg    = is_signed & b[31];
        a_mag    = a_neg ? (32'd0 - a) : a;
        b_mag    = b_neg ? (32'd0 - b) : b;
        div_zero = (b == '0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer for the E stage with fixed-latency busy.
// Define MD_SEQUENCER_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    md_sequencer_if.slave bus
);

    md_state_t   state, state_nxt;
    logic [3:0]  count, count_nxt;
    md_op_t      op;
    logic        accept, commit;
    logic        is_mul, is_div, is_mthi, is_mtlo, op_signed;
    md_acc_t     acc_dec, acc_mode;
    logic [63:0] pend;
    logic [31:0] hi_q, lo_q;
    logic [63:0] prod;
    logic [31:0] quot, rem;
    logic        div_zero;

    assign op     = md_op_t'(bus.md_op);
    assign accept = bus.start && !bus.cancel && (state == IDLE);

    md_arith u_arith (
        .a        (bus.rs_data),
        .b        (bus.rt_data),
        .is_signed(op_signed),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always_comb begin
        is_mul    = '0;
        is_div    = '0;
        is_mthi   = '0;
        is_mtlo   = '0;
        op_signed = '0;
        acc_dec   = ACC_SET;
        case (op)
            MD_MULT:  begin is_mul = '1; op_signed = '1; end
            MD_MULTU: is_mul = '1;
            MD_DIV:   begin is_div = '1; op_signed = '1; end
            MD_DIVU:  is_div = '1;
            MD_MTHI:  is_mthi = '1;
            MD_MTLO:  is_mtlo = '1;
`ifdef MD_SEQUENCER_MADD_EN
            MD_MADD:  begin is_mul = '1; op_signed = '1; acc_dec = ACC_ADD; end
            MD_MADDU: begin is_mul = '1; acc_dec = ACC_ADD; end
            MD_MSUB:  begin is_mul = '1; op_signed = '1; acc_dec = ACC_SUB; end
            MD_MSUBU: begin is_mul = '1; acc_dec = ACC_SUB; end
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = MUL_RUN;
                    count_nxt = 4'(MULT_CYCLES);
                end else if (accept && is_div) begin
                    state_nxt = DIV_RUN;
                    count_nxt = 4'(DIV_CYCLES);
                end
            end
            MUL_RUN, DIV_RUN: begin
                count_nxt = count - 4'd1;
                if (count <= 4'd1) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.md_active = bus.start | bus.busy;
        commit        = (state != IDLE) && (count <= 4'd1);
        bus.hi        = hi_q;
        bus.lo        = lo_q;
        case (op)
            MD_MFHI: bus.md_rdata = hi_q;
            MD_MFLO: bus.md_rdata = lo_q;
            default: bus.md_rdata = '0;
        endcase
    end

    // accept only happens in IDLE and commit only in a RUN state, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            pend     <= '0;
            acc_mode <= ACC_SET;
        end else begin
            if (accept) begin
                if (is_mul) begin
                    pend     <= prod;
                    acc_mode <= acc_dec;
                end
                if (is_div) begin
                    pend     <= {rem, quot};
                    acc_mode <= div_zero ? ACC_KEEP : ACC_SET;
                end
                if (is_mthi) hi_q <= bus.rs_data;
                if (is_mtlo) lo_q <= bus.rs_data;
            end
            if (commit) begin
                case (acc_mode)
                    ACC_SET: {hi_q, lo_q} <= pend;
                    ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + pend;
                    ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - pend;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer (busy latency, HI/LO results,
// cancel, ignored starts, async reset; MADD-class when MD_SEQUENCER_MADD_EN).
module tb_md_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    md_sequencer_if bus ();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start for a cycle; returns one cycle after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.rs_data = rs;
        bus.rt_data = rt;
        step();
        bus.start   = 1'b0;
        bus.md_op   = 4'd0;
    endtask

    // Counts busy cycles from the current one; exits in the first non-busy cycle.
    task automatic count_busy(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.cancel  = 1'b0;
        bus.md_op   = 4'd0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_active", {31'd0, bus.md_active}, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // MULT -2 * 3
        bus.start = 1'b1;
        bus.md_op = 4'd1;
        #1;
        chk("mult_active_start", {31'd0, bus.md_active}, 32'd1);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_active_busy", {31'd0, bus.md_active}, 32'd1);
        count_busy(n);
        chk("mult_busy_cycles", n, 32'd5);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
        chk("idle_active", {31'd0, bus.md_active}, 32'd0);

        bus.md_op = 4'd5;
        #1;
        chk("mfhi", bus.md_rdata, 32'hFFFF_FFFF);
        bus.md_op = 4'd6;
        #1;
        chk("mflo", bus.md_rdata, 32'hFFFF_FFFA);
        bus.md_op = 4'd0;
        #1;
        chk("rdata_other", bus.md_rdata, 32'd0);

        // DIV / DIVU -7 by 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("div_busy_cycles", n, 32'd10);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("divu_busy_cycles", n, 32'd10);
        chk("divu_lo", bus.lo, 32'h7FFF_FFFC);
        chk("divu_hi", bus.hi, 32'd1);

        // Signed overflow case
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        chk("divovf_lo", bus.lo, 32'h8000_0000);
        chk("divovf_hi", bus.hi, 32'd0);

        // MTHI/MTLO then divide by zero
        issue(4'd7, 32'h11, 32'd0);
        chk("mthi_nobusy", {31'd0, bus.busy}, 32'd0);
        chk("mthi_hi", bus.hi, 32'h11);
        issue(4'd8, 32'h22, 32'd0);
        chk("mtlo_lo", bus.lo, 32'h22);
        issue(4'd3, 32'd5, 32'd0);
        count_busy(n);
        chk("div0_busy_cycles", n, 32'd10);
        chk("div0_hi", bus.hi, 32'h11);
        chk("div0_lo", bus.lo, 32'h22);

        // start + cancel in the same cycle
        bus.cancel = 1'b1;
        issue(4'd1, 32'd7, 32'd7);
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("cancel_busy2", {31'd0, bus.busy}, 32'd0);
        chk("cancel_hi", bus.hi, 32'h11);
        chk("cancel_lo", bus.lo, 32'h22);

        // Second start while busy is ignored
        issue(4'd1, 32'd3, 32'd4);
        issue(4'd3, 32'd100, 32'd7);
        count_busy(n);
        chk("ignored_busy_cycles", n + 1, 32'd5);
        chk("ignored_hi", bus.hi, 32'd0);
        chk("ignored_lo", bus.lo, 32'd12);
        step();
        chk("ignored_no_div", {31'd0, bus.busy}, 32'd0);

        // Undefined op is a no-op
        issue(4'd13, 32'hDEAD_BEEF, 32'd1);
        chk("undef_busy", {31'd0, bus.busy}, 32'd0);
        chk("undef_lo", bus.lo, 32'd12);

`ifdef MD_SEQUENCER_MADD_EN
        issue(4'd7, 32'd0, 32'd0);
        issue(4'd8, 32'hFFFF_FFFF, 32'd0);
        issue(4'd10, 32'd1, 32'd1);
        count_busy(n);
        chk("maddu_busy_cycles", n, 32'd5);
        chk("maddu_hi", bus.hi, 32'd1);
        chk("maddu_lo", bus.lo, 32'd0);
        issue(4'd11, 32'd1, 32'd1);
        count_busy(n);
        chk("msub_hi", bus.hi, 32'd0);
        chk("msub_lo", bus.lo, 32'hFFFF_FFFF);
`else
        issue(4'd9, 32'd5, 32'd5);
        chk("madd_off_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("madd_off_lo", bus.lo, 32'd12);
`endif

        // Reset in the third busy cycle of a DIV
        issue(4'd7, 32'h55, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        step();
        step();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) n++;
        end
        chk("rst_no_commit", n, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
